// File: rtl/interconnect_rr_pkg.sv
// Shared helpers and default widths for the round-robin token merge.
package interconnect_rr_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

   // A one-channel merge would still need a 1-bit source tag.
   function automatic int src_width(input int n);
      return (n < 2) ? 1 : clog2(n);
   endfunction

   localparam int DEF_DATA_WIDTH   = 32;
   localparam int DEF_CONNECT_NUM  = 4;
   localparam int DEF_BUFFER_DEPTH = 2;
   localparam int DEF_SRC_WIDTH    = src_width(DEF_CONNECT_NUM);

endpackage

// File: rtl/interconnect_fifo.sv
// Synchronous FIFO with occupancy count; head is the read-pointer entry.
module interconnect_fifo
   import interconnect_rr_pkg::*;
#(
   parameter int WIDTH = 34,
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  pop,
   output logic [WIDTH-1:0]      head,
   output logic [clog2(DEPTH):0] count,
   output logic                  full,
   output logic                  empty
);
   localparam int AW = clog2(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [AW-1:0]               rd;
   logic [AW-1:0]               wr;

   // Storage is reset too so the head reads zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem   <= '0;
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wr] <= push_data;
            wr      <= wr + 1'b1;
         end
         if (pop) rd <= rd + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd];
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/interconnect_rr.sv
// N-to-1 valid/ready merge: round-robin grant into a registered, source-tagged output FIFO.
module interconnect_rr
   import interconnect_rr_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int CONNECT_NUM  = DEF_CONNECT_NUM,
   parameter int BUFFER_DEPTH = DEF_BUFFER_DEPTH,
   parameter int SRC_WIDTH    = DEF_SRC_WIDTH
) (
   input  logic                            CLK,
   input  logic                            RST_N,
   input  logic [CONNECT_NUM-1:0]          RECEIVE_VALID,
   input  logic [DATA_WIDTH*CONNECT_NUM-1:0] RECEIVE_DATA,
   output logic [CONNECT_NUM-1:0]          RECEIVE_READY,
   output logic                            SEND_VALID,
   output logic [DATA_WIDTH-1:0]           SEND_DATA,
   output logic [SRC_WIDTH-1:0]            SEND_SRC,
   input  logic                            SEND_READY,
   output logic [clog2(BUFFER_DEPTH):0]    OCCUPANCY
);
   localparam int EW = DATA_WIDTH + SRC_WIDTH;

   logic [SRC_WIDTH-1:0]  ptr;
   logic [SRC_WIDTH-1:0]  gnt_idx;
   logic [DATA_WIDTH-1:0] gnt_data;
   logic                  found;
   logic                  full;
   logic                  empty;
   logic                  pop;
   logic [EW-1:0]         head;

   // Scan ptr, ptr+1, ... and grant the first valid channel. Readiness uses the
   // pre-pop count, so SEND_READY never reaches RECEIVE_READY.
   always_comb begin
      RECEIVE_READY = '0;
      gnt_idx       = '0;
      gnt_data      = '0;
      found         = 1'b0;
      if (RST_N && !full) begin
         for (int k = 0; k < CONNECT_NUM; k++) begin
            for (int i = 0; i < CONNECT_NUM; i++) begin
               if (!found && RECEIVE_VALID[i] && (i == (int'(ptr) + k) % CONNECT_NUM)) begin
                  found            = 1'b1;
                  RECEIVE_READY[i] = 1'b1;
                  gnt_idx          = SRC_WIDTH'(i);
                  gnt_data         = RECEIVE_DATA[DATA_WIDTH*i +: DATA_WIDTH];
               end
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)     ptr <= '0;
      else if (found) ptr <= (gnt_idx == SRC_WIDTH'(CONNECT_NUM-1)) ? '0 : gnt_idx + 1'b1;
   end

   assign pop = SEND_VALID && SEND_READY;

   interconnect_fifo #(.WIDTH(EW), .DEPTH(BUFFER_DEPTH)) u_fifo (
      .clk       (CLK),
      .rst_n     (RST_N),
      .push      (found),
      .push_data ({gnt_data, gnt_idx}),
      .pop       (pop),
      .head      (head),
      .count     (OCCUPANCY),
      .full      (full),
      .empty     (empty)
   );

   assign SEND_VALID = !empty;
   assign SEND_DATA  = head[EW-1:SRC_WIDTH];
   assign SEND_SRC   = head[SRC_WIDTH-1:0];

endmodule
